mouse_pos_sync: RTL and testbench
=================================

Name: mouse_pos_sync

Overview:
- Frame-synchronous position stage sitting directly upstream of the cursor-overlay stage in the VGA pipeline.
- Accepts raw mouse samples (position, buttons, event strobe) from the mouse controller.
- Clamps the position to the visible area.
- Commits position and buttons only at the start of vertical blanking, so the cursor never tears mid-frame.
- Produces an immediate, debounced-by-edge left-click pulse for game/UI logic.

Parameters:
- X_MAX, 1023, largest committed x (H active - 1).
- Y_MAX, 767, largest committed y (V active - 1).
- STALE_FRAMES, 60, frames without a new_event before the stale flag asserts.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- xpos_in  in  12  raw x from mouse controller.
- ypos_in  in  12  raw y from mouse controller.
- left_in  in  1  left button level.
- right_in  in  1  right button level.
- new_event  in  1  one-cycle strobe: xpos_in/ypos_in/buttons valid.
- vga_in  vga_if.in  -  timing stream; only vblnk is monitored.
- x_out  out  12  committed, clamped x to cursor overlay.
- y_out  out  12  committed, clamped y to cursor overlay.
- left_out  out  1  committed left level.
- right_out  out  1  committed right level.
- left_click  out  1  one-cycle pulse on left press.
- updated  out  1  one-cycle pulse when a commit occurs.
- stale  out  1  no event for STALE_FRAMES frames.

Behaviour:
- Reset: x_out=0, y_out=0, left_out=0, right_out=0, left_click=0, updated=0, stale=0. Internal state: FSM=IDLE, pending regs=0, vblnk_q=0, left_q=0, frame counter=0.
- Clamp, applied when capturing:
  - x_c = (xpos_in > X_MAX) ? X_MAX : xpos_in; y likewise with Y_MAX.
  - Inputs are unsigned 12-bit; no other transform.
- Frame edge: vbl_rise = vga_in.vblnk & ~vblnk_q. vblnk_q is registered every cycle.
- FSM states IDLE, PENDING:
  - IDLE: new_event captures clamped x/y and buttons into pending regs -> PENDING.
  - PENDING: new_event overwrites pending regs; latest sample wins, so only one sample is kept per frame.
  - PENDING & vbl_rise: x_out/y_out/left_out/right_out <= pending, updated=1 for one cycle -> IDLE.
  - IDLE & vbl_rise: no output change, updated stays 0.
- Simultaneous new_event & vbl_rise, in either state: the new sample bypasses the pending regs and is committed directly. updated=1, FSM -> IDLE.
- Latency: outputs change on the clock edge at which vbl_rise is evaluated true, i.e. 1 cycle after vblnk is first sampled high. updated coincides with the new outputs.
- left_click:
  - Fires on new_event & left_in & ~left_q; left_q is updated on every new_event.
  - Pulse appears the cycle after the strobe and is not frame-aligned.
  - A press and release within one frame still yields exactly one click.
- Stale counter:
  - Counts vbl_rise events since the last new_event; new_event clears it to 0.
  - Saturates at STALE_FRAMES; stale = (count == STALE_FRAMES).
  - new_event deasserts stale the next cycle.
- Reset mid-operation: pending sample is discarded and outputs return to reset values the next cycle. The first vbl_rise after reset commits nothing unless an event arrived.
- vblnk held high for many cycles produces only one commit; vblnk must fall and rise again before the next commit.

Decomposition:
- Shared vga package holds:
  - H/V active constants used as defaults for X_MAX/Y_MAX.
  - mouse_state_t enum {IDLE, PENDING}.
  - packed struct mouse_sample_t {x[11:0], y[11:0], left, right} used for both pending and committed regs.
- One sub-module, edge_detect: rising-edge pulse with enable, reused for vbl_rise (enable=1) and left_click (enable=new_event).

Test Plan:
- Reset, then 3 frames with no events -> x_out=y_out=0, updated never pulses, stale=0.
- Event (x=100, y=200) mid-frame -> outputs unchanged until vbl_rise; then x_out=100, y_out=200, with a single updated pulse 1 cycle after vblnk is first seen high.
- Events (10,10), (20,20), (30,30) in one frame -> only (30,30) is committed; exactly one updated pulse.
- Event (2000, 900) -> x_out=1023, y_out=767; event (4095, 0) -> x_out=1023, y_out=0.
- new_event (50,60) on the same cycle as vbl_rise while (5,5) is pending -> x_out=50, y_out=60 that frame, FSM returns to IDLE, and the next vbl_rise gives no updated pulse.
- left_in 0->1 via event, then 1->0 in the same frame -> exactly one left_click pulse, while left_out commits 0 at vbl_rise. 61 frames with no event -> stale=1; next event -> stale=0 the following cycle.

Source files
------------

// File: rtl/mouse_pos_sync_pkg.sv
// Shared VGA/mouse types: active-area sizes, commit FSM states and the sample record
// used for both the pending and the committed cursor position.
package mouse_pos_sync_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int POS_W    = 12;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } mouse_state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             left;
    logic             right;
  } mouse_sample_t;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mouse_pos_sync_if.sv
// VGA timing stream; consumers that only care about frame boundaries use the
// narrow "in" view, which exposes vblnk alone.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk
  );

  modport in (
    input vblnk
  );

endinterface

// File: rtl/mouse_pos_sync_edge_detect.sv
// Rising-edge detector whose history only advances when en is high; REGISTERED
// selects a same-cycle pulse or a pulse delayed by one clock.
module edge_detect #(
  parameter bit REGISTERED = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic pulse
);

  logic q;
  logic rise;
  logic rise_q;

  assign rise = en & d & ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      if (en) begin
        q <= d;
      end
      rise_q <= rise;
    end
  end

  assign pulse = REGISTERED ? rise_q : rise;

endmodule

// File: rtl/mouse_pos_sync.sv
// Frame-synchronous mouse position stage: clamps samples, commits the latest one at the
// start of vertical blanking, emits left-click pulses and a stale-input flag.
module mouse_pos_sync
  import mouse_pos_sync_pkg::*;
#(
  parameter int X_MAX        = H_ACTIVE - 1,
  parameter int Y_MAX        = V_ACTIVE - 1,
  parameter int STALE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] xpos_in,
  input  logic [POS_W-1:0] ypos_in,
  input  logic             left_in,
  input  logic             right_in,
  input  logic             new_event,
  vga_if.in                vga_in,
  output logic [POS_W-1:0] x_out,
  output logic [POS_W-1:0] y_out,
  output logic             left_out,
  output logic             right_out,
  output logic             left_click,
  output logic             updated,
  output logic             stale
);

  localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);
  localparam int               CNT_W = $clog2(STALE_FRAMES + 1);
  localparam logic [CNT_W-1:0] STALE_LIM = CNT_W'(STALE_FRAMES);

  mouse_state_t  state_q;
  mouse_state_t  state_d;
  mouse_sample_t sample_c;
  mouse_sample_t pend_q;
  mouse_sample_t pend_d;
  mouse_sample_t commit_sample;
  mouse_sample_t out_q;
  logic          commit_d;
  logic          vbl_rise;
  logic [CNT_W-1:0] stale_cnt;

  assign sample_c.x     = clamp_pos(xpos_in, X_LIM);
  assign sample_c.y     = clamp_pos(ypos_in, Y_LIM);
  assign sample_c.left  = left_in;
  assign sample_c.right = right_in;

  edge_detect #(.REGISTERED(1'b0)) u_vbl_edge (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .d     (vga_in.vblnk),
    .pulse (vbl_rise)
  );

  edge_detect #(.REGISTERED(1'b1)) u_click_edge (
    .clk   (clk),
    .rst   (rst),
    .en    (new_event),
    .d     (left_in),
    .pulse (left_click)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // A sample arriving on the blanking edge itself skips the pending regs.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    commit_d      = 1'b0;
    commit_sample = pend_q;
    case (state_q)
      IDLE: begin
        if (vbl_rise && new_event) begin
          commit_d      = 1'b1;
          commit_sample = sample_c;
        end else if (new_event) begin
          pend_d  = sample_c;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vbl_rise) begin
          commit_d      = 1'b1;
          commit_sample = new_event ? sample_c : pend_q;
          state_d       = IDLE;
        end else if (new_event) begin
          pend_d = sample_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      updated <= 1'b0;
    end else begin
      updated <= commit_d;
      if (commit_d) begin
        out_q <= commit_sample;
      end
    end
  end

  assign x_out     = out_q.x;
  assign y_out     = out_q.y;
  assign left_out  = out_q.left;
  assign right_out = out_q.right;

  always_ff @(posedge clk) begin
    if (rst) begin
      stale_cnt <= '0;
    end else if (new_event) begin
      stale_cnt <= '0;
    end else if (vbl_rise && (stale_cnt != STALE_LIM)) begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

  assign stale = (stale_cnt == STALE_LIM);

endmodule

// File: tb/tb_mouse_pos_sync.sv
// Randomized bench for mouse_pos_sync against a frame-level model: the last sample of each
// frame is committed at blanking start, clicks count rising left levels across events.
module tb_mouse_pos_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos_in;
  logic [11:0] ypos_in;
  logic        left_in;
  logic        right_in;
  logic        new_event;
  logic [11:0] x_out;
  logic [11:0] y_out;
  logic        left_out;
  logic        right_out;
  logic        left_click;
  logic        updated;
  logic        stale;

  vga_if vif ();

  mouse_pos_sync dut (
    .clk        (clk),
    .rst        (rst),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .left_in    (left_in),
    .right_in   (right_in),
    .new_event  (new_event),
    .vga_in     (vif),
    .x_out      (x_out),
    .y_out      (y_out),
    .left_out   (left_out),
    .right_out  (right_out),
    .left_click (left_click),
    .updated    (updated),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;
  int click_cnt = 0;

  // Frame-level reference state
  int unsigned m_px, m_py, m_cx, m_cy;
  bit          m_pl, m_pr, m_cl, m_cr;
  bit          m_have_pend;
  bit          m_last_left;
  int          m_idle_frames;
  int          exp_upd_cnt = 0;
  int          exp_click_cnt = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (updated === 1'b1) upd_cnt++;
      if (left_click === 1'b1) click_cnt++;
    end
  end

  function automatic int unsigned lim(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_pl = 0; m_pr = 0;
    m_cx = 0; m_cy = 0; m_cl = 0; m_cr = 0;
    m_have_pend = 0;
    m_last_left = 0;
    m_idle_frames = 0;
  endtask

  task automatic model_event(input int unsigned x, input int unsigned y, input bit l, input bit r);
    m_px = lim(x, 1023);
    m_py = lim(y, 767);
    m_pl = l;
    m_pr = r;
    m_have_pend = 1;
    if (l && !m_last_left) exp_click_cnt++;
    m_last_left = l;
    m_idle_frames = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".x"}, x_out, m_cx);
    chk({tag, ".y"}, y_out, m_cy);
    chk({tag, ".l"}, left_out, m_cl);
    chk({tag, ".r"}, right_out, m_cr);
  endtask

  task automatic drive_sample(input int unsigned x, input int unsigned y, input bit l, input bit r);
    xpos_in   = x[11:0];
    ypos_in   = y[11:0];
    left_in   = l;
    right_in  = r;
    new_event = 1'b1;
  endtask

  // Mid-frame event: nothing visible changes except stale clearing.
  task automatic send(input int unsigned x, input int unsigned y, input bit l, input bit r);
    drive_sample(x, y, l, r);
    model_event(x, y, l, r);
    tick();
    new_event = 1'b0;
    chk("ev_updated", updated, 0);
    chk("ev_stale", stale, 0);
    check_outputs("ev_hold");
  endtask

  task automatic frame(input bit with_evt, input int unsigned x, input int unsigned y,
                       input bit l, input bit r, input int hold);
    bit exp_upd;
    vif.vblnk = 1'b1;
    if (with_evt) begin
      drive_sample(x, y, l, r);
      model_event(x, y, l, r);
    end
    exp_upd = m_have_pend;
    if (m_have_pend) begin
      m_cx = m_px; m_cy = m_py; m_cl = m_pl; m_cr = m_pr;
      m_have_pend = 0;
      exp_upd_cnt++;
    end
    if (!with_evt && m_idle_frames < 60) m_idle_frames++;
    tick();
    new_event = 1'b0;
    chk("vbl_updated", updated, exp_upd);
    check_outputs("vbl_commit");
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("vbl_hold_upd", updated, 0);
    end
    vif.vblnk = 1'b0;
    repeat (3) tick();
    chk("stale", stale, (m_idle_frames >= 60) ? 1 : 0);
    chk("upd_count", upd_cnt, exp_upd_cnt);
    chk("click_count", click_cnt, exp_click_cnt);
  endtask

  initial begin
    rst = 1'b1;
    xpos_in = '0; ypos_in = '0; left_in = 1'b0; right_in = 1'b0; new_event = 1'b0;
    vif.hcount = '0; vif.vcount = '0; vif.hsync = 1'b0; vif.vsync = 1'b0;
    vif.hblnk = 1'b0; vif.vblnk = 1'b0;
    model_reset();
    repeat (2) tick();
    chk("rst_updated", updated, 0);
    chk("rst_click", left_click, 0);
    chk("rst_stale", stale, 0);
    check_outputs("rst");
    rst = 1'b0;
    tick();

    // Idle frames
    repeat (3) frame(0, 0, 0, 0, 0, 4);

    // Single mid-frame event, vblnk held long
    tick();
    send(100, 200, 0, 1);
    repeat (3) tick();
    frame(0, 0, 0, 0, 0, 8);

    // Latest sample in a frame wins
    send(10, 10, 0, 0);
    tick();
    send(20, 20, 0, 0);
    send(30, 30, 0, 0);
    frame(0, 0, 0, 0, 0, 2);

    // Clamping
    send(2000, 900, 0, 0);
    frame(0, 0, 0, 0, 0, 2);
    send(4095, 0, 0, 1);
    frame(0, 0, 0, 0, 0, 2);

    // Event coincident with blanking start while another is pending
    send(5, 5, 0, 0);
    frame(1, 50, 60, 0, 0, 2);
    frame(0, 0, 0, 0, 0, 2);

    // Press and release within one frame: one click, released level committed
    send(300, 300, 1, 0);
    tick();
    send(301, 301, 0, 0);
    frame(0, 0, 0, 0, 0, 2);

    // Stale saturation then clear on the next event
    for (int f = 0; f < 61; f++) frame(0, 0, 0, 0, 0, 1);
    send(7, 8, 0, 0);
    frame(0, 0, 0, 0, 0, 1);

    // Reset mid-operation discards the pending sample
    send(400, 500, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("rst_mid_updated", updated, 0);
    chk("rst_mid_stale", stale, 0);
    check_outputs("rst_mid");
    tick();
    frame(0, 0, 0, 0, 0, 2);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int e = 0; e < n; e++) begin
        repeat ($urandom_range(0, 3)) tick();
        send($urandom_range(0, 4095), $urandom_range(0, 4095),
             $urandom_range(0, 1), $urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 3) == 0)
        frame(1, $urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5));
      else
        frame(0, 0, 0, 0, 0, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
